// File: rtl/lzs_pkg.sv
// Shared types, token constants and small decode helpers for the LZS decompressor.
package lzs_pkg;

    localparam int unsigned IN_WIDTH       = 13;
    localparam int unsigned NEED_STR_WIDTH = 4;
    localparam int unsigned OUT_WIDTH      = 8;
    localparam int unsigned HIST_DEPTH     = 2048;
    localparam int unsigned HIST_AW        = 11;
    localparam int unsigned OFS7_W         = 7;
    localparam int unsigned OFS11_W        = 11;
    localparam int unsigned LEN_W          = 16;

    localparam logic [OFS7_W-1:0] END_OFS = '0;

    // Bits consumed by each token field
    localparam logic [NEED_STR_WIDTH-1:0] W_LIT   = 4'd9;
    localparam logic [NEED_STR_WIDTH-1:0] W_OFS7  = 4'd9;
    localparam logic [NEED_STR_WIDTH-1:0] W_OFS11 = 4'd13;
    localparam logic [NEED_STR_WIDTH-1:0] W_LEN_S = 4'd2;
    localparam logic [NEED_STR_WIDTH-1:0] W_LEN_L = 4'd4;
    localparam logic [NEED_STR_WIDTH-1:0] W_EXT   = 4'd4;

    // Nibble value that escapes into (or continues) the extended length field
    localparam logic [3:0] EXT_ESC = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TOKEN   = 3'd1,
        ST_LEN     = 3'd2,
        ST_EXT     = 3'd3,
        ST_COPY_RD = 3'd4,
        ST_COPY_WR = 3'd5,
        ST_END     = 3'd6
    } state_t;

    // Copy length from the leading length nibble: 00/01/10 -> 2..4, 11xx -> 5..8
    function automatic logic [LEN_W-1:0] len_code(input logic [3:0] p);
        case (p[3:2])
            2'b00:   len_code = LEN_W'(2);
            2'b01:   len_code = LEN_W'(3);
            2'b10:   len_code = LEN_W'(4);
            default: len_code = LEN_W'(5) + LEN_W'(p[1:0]);
        endcase
    endfunction

    // Number of bits the length code occupies
    function automatic logic [NEED_STR_WIDTH-1:0] len_width(input logic [3:0] p);
        len_width = (p[3:2] == 2'b11) ? W_LEN_L : W_LEN_S;
    endfunction

endpackage

// File: rtl/lzs_history.sv
// 2048x8 history buffer: one write port, synchronous read with one-cycle latency.
module lzs_history
    import lzs_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [HIST_AW-1:0]   waddr,
    input  logic [OUT_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [HIST_AW-1:0]   raddr,
    output logic [OUT_WIDTH-1:0] rdata
);

    logic [OUT_WIDTH-1:0] mem [HIST_DEPTH];

    // Write and registered read; rdata holds when no read is issued
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lzs_decode.sv
// LZS bit-stream decompressor: token parser FSM, copy engine and output register.
module lzs_decode
    import lzs_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce_decode,
    input  logic                      stream_valid,
    input  logic [IN_WIDTH-1:0]       stream_data,
    output logic                      stream_ack,
    output logic [NEED_STR_WIDTH-1:0] stream_width,
    input  logic                      fo_full,
    output logic [OUT_WIDTH-1:0]      out_data,
    output logic                      out_valid,
    output logic [2:0]                current_state,
    output logic                      all_end
);

    state_t               state;
    state_t               state_nx;
    logic [HIST_AW-1:0]   wp;
    logic [HIST_AW-1:0]   ofs;
    logic [LEN_W-1:0]     len;
    logic [LEN_W-1:0]     len_dec;
    logic                 go;
    logic                 ack_ok;
    logic                 lit_we;
    logic                 ofs_ld;
    logic                 end_hit;
    logic                 len_ld;
    logic                 ext_ld;
    logic                 rd_en;
    logic                 cp_we;
    logic [3:0]           nib;
    logic [OFS7_W-1:0]    ofs7;
    logic [OUT_WIDTH-1:0] rd_data;
    logic [OUT_WIDTH-1:0] wr_data;
    logic [HIST_AW-1:0]   rd_addr;

    assign go            = ce_decode & ~fo_full;
    assign ack_ok        = go & stream_valid;
    assign nib           = stream_data[12:9];
    assign ofs7          = stream_data[10:4];
    assign len_dec       = len - LEN_W'(1);
    assign rd_addr       = wp - ofs;
    assign wr_data       = lit_we ? stream_data[11:4] : rd_data;
    assign current_state = state;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic driven by the strobes of the output decode
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (ce_decode) state_nx = ST_TOKEN;
            ST_TOKEN: begin
                if (end_hit)     state_nx = ST_END;
                else if (ofs_ld) state_nx = ST_LEN;
            end
            ST_LEN:     if (len_ld) state_nx = (nib == EXT_ESC) ? ST_EXT : ST_COPY_RD;
            ST_EXT:     if (ext_ld && nib != EXT_ESC) state_nx = ST_COPY_RD;
            ST_COPY_RD: if (rd_en) state_nx = ST_COPY_WR;
            ST_COPY_WR: if (cp_we) state_nx = (len_dec == '0) ? ST_TOKEN : ST_COPY_RD;
            default:    state_nx = state;
        endcase
    end

    // Token decode: stream handshake and datapath strobes
    always_comb begin
        stream_ack   = 1'b0;
        stream_width = '0;
        lit_we       = 1'b0;
        ofs_ld       = 1'b0;
        end_hit      = 1'b0;
        len_ld       = 1'b0;
        ext_ld       = 1'b0;
        rd_en        = 1'b0;
        cp_we        = 1'b0;
        case (state)
            ST_TOKEN: begin
                if (ack_ok) begin
                    stream_ack = 1'b1;
                    if (!stream_data[12]) begin
                        stream_width = W_LIT;
                        lit_we       = 1'b1;
                    end else if (stream_data[11]) begin
                        stream_width = W_OFS7;
                        if (ofs7 == END_OFS) end_hit = 1'b1;
                        else                 ofs_ld  = 1'b1;
                    end else begin
                        stream_width = W_OFS11;
                        ofs_ld       = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (ack_ok) begin
                    stream_ack   = 1'b1;
                    stream_width = len_width(nib);
                    len_ld       = 1'b1;
                end
            end
            ST_EXT: begin
                if (ack_ok) begin
                    stream_ack   = 1'b1;
                    stream_width = W_EXT;
                    ext_ld       = 1'b1;
                end
            end
            ST_COPY_RD: rd_en = go;
            ST_COPY_WR: cp_we = go;
            default: ;
        endcase
    end

    // Datapath: offset/length capture, write pointer, output byte and end flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp        <= '0;
            ofs       <= '0;
            len       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            all_end   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (lit_we) begin
                out_data  <= stream_data[11:4];
                out_valid <= 1'b1;
                wp        <= wp + HIST_AW'(1);
            end
            if (ofs_ld) begin
                ofs <= stream_data[11] ? HIST_AW'(ofs7) : stream_data[OFS11_W-1:0];
            end
            if (end_hit) begin
                all_end <= 1'b1;
            end
            if (len_ld) begin
                len <= len_code(nib);
            end
            if (ext_ld) begin
                len <= len + LEN_W'(nib);
            end
            if (cp_we) begin
                out_data  <= rd_data;
                out_valid <= 1'b1;
                wp        <= wp + HIST_AW'(1);
                len       <= len_dec;
            end
        end
    end

    lzs_history u_hist (
        .clk   (clk),
        .we    (lit_we | cp_we),
        .waddr (wp),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_lzs_decode.sv
// Self-checking bench for lzs_decode: token encoder, bit-stream source and byte-history model.
module tb_lzs_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_decode;
    logic        stream_valid;
    logic [12:0] stream_data;
    logic        stream_ack;
    logic [3:0]  stream_width;
    logic        fo_full;
    logic [7:0]  out_data;
    logic        out_valid;
    logic [2:0]  current_state;
    logic        all_end;

    always #5 clk = ~clk;

    lzs_decode dut (
        .clk           (clk),
        .rst           (rst),
        .ce_decode     (ce_decode),
        .stream_valid  (stream_valid),
        .stream_data   (stream_data),
        .stream_ack    (stream_ack),
        .stream_width  (stream_width),
        .fo_full       (fo_full),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .current_state (current_state),
        .all_end       (all_end)
    );

    bit         src_q[$];
    logic [7:0] hist_m[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_t[$];
    int         wid_q[$];
    int         exp_wid_q[$];
    int         ackst_q[$];
    int         cyc = 0;
    int         ack_cnt = 0;
    int         n_tests = 0;
    int         n_fail = 0;
    logic       fd_ack;
    logic [3:0] fd_w;
    logic [2:0] fd_s;

    always @(posedge clk) cyc <= cyc + 1;

    // Bit source: present a 13-bit window, shift by the acknowledged width at the edge
    initial begin
        stream_valid = 1'b0;
        stream_data  = '0;
        forever begin
            @(negedge clk);
            stream_valid = (src_q.size() != 0);
            for (int i = 0; i < 13; i++)
                stream_data[12-i] = (i < src_q.size()) ? src_q[i] : 1'b0;
            #4;
            fd_ack = stream_ack;
            fd_w   = stream_width;
            fd_s   = current_state;
            @(posedge clk);
            if (fd_ack === 1'b1) begin
                ack_cnt++;
                wid_q.push_back(int'(fd_w));
                ackst_q.push_back(int'(fd_s));
                for (int i = 0; i < int'(fd_w); i++)
                    if (src_q.size() != 0) void'(src_q.pop_front());
            end
        end
    end

    // Byte sink: collect every output pulse with its cycle number
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                got_q.push_back(out_data);
                got_t.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) src_q.push_back(v[i]);
    endtask

    task automatic enc_lit(input logic [7:0] b);
        push_bits(32'(0), 1);
        push_bits(32'(b), 8);
        exp_wid_q.push_back(9);
        hist_m.push_back(b);
        exp_q.push_back(b);
    endtask

    // Encode a copy token and extend the model: each byte repeats the one ofs back
    task automatic enc_copy(input int ofs, input int len, input bit lng);
        int rem;
        logic [7:0] b;
        if (lng) begin
            push_bits(32'(2), 2);
            push_bits(32'(ofs), 11);
            exp_wid_q.push_back(13);
        end else begin
            push_bits(32'(3), 2);
            push_bits(32'(ofs), 7);
            exp_wid_q.push_back(9);
        end
        if (len <= 4) begin
            push_bits(32'(len - 2), 2);
            exp_wid_q.push_back(2);
        end else if (len <= 7) begin
            push_bits(32'(12 + len - 5), 4);
            exp_wid_q.push_back(4);
        end else begin
            push_bits(32'(15), 4);
            exp_wid_q.push_back(4);
            rem = len - 8;
            while (rem >= 15) begin
                push_bits(32'(15), 4);
                exp_wid_q.push_back(4);
                rem -= 15;
            end
            push_bits(32'(rem), 4);
            exp_wid_q.push_back(4);
        end
        for (int i = 0; i < len; i++) begin
            b = hist_m[hist_m.size() - ofs];
            hist_m.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic enc_end();
        push_bits(32'(3), 2);
        push_bits(32'(0), 7);
        exp_wid_q.push_back(9);
    endtask

    task automatic clear_seg();
        got_q.delete();
        got_t.delete();
        wid_q.delete();
        exp_q.delete();
        exp_wid_q.delete();
        ackst_q.delete();
    endtask

    // Run until the source is empty and the decoder is back at TOKEN; optional random stalls
    task automatic drain(input string tag, input int budget, input bit stall);
        int n = 0;
        while (!(src_q.size() == 0 && current_state == 3'd1) && n < budget) begin
            @(negedge clk);
            if (stall) begin
                fo_full   = ($urandom_range(0, 3) == 0);
                ce_decode = ($urandom_range(0, 4) != 0);
            end
            n++;
        end
        fo_full   = 1'b0;
        ce_decode = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_done"}, 32'(n < budget), 32'd1);
    endtask

    // Compare collected bytes and widths against the model, reporting the first difference
    task automatic compare_seg(input string tag);
        int n;
        int idx;
        check({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
        n   = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        idx = n - 1;
        for (int i = 0; i < n; i++)
            if (got_q[i] !== exp_q[i]) begin idx = i; break; end
        if (n > 0) check({tag, "_byte"}, 32'(got_q[idx]), 32'(exp_q[idx]));
        check({tag, "_nacks"}, 32'(wid_q.size()), 32'(exp_wid_q.size()));
        n   = (wid_q.size() < exp_wid_q.size()) ? wid_q.size() : exp_wid_q.size();
        idx = n - 1;
        for (int i = 0; i < n; i++)
            if (wid_q[i] != exp_wid_q[i]) begin idx = i; break; end
        if (n > 0) check({tag, "_width"}, 32'(wid_q[idx]), 32'(exp_wid_q[idx]));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_all_end"}, 32'(all_end), 32'd0);
        check({tag, "_ack"}, 32'(stream_ack), 32'd0);
        check({tag, "_width"}, 32'(stream_width), 32'd0);
        check({tag, "_state"}, 32'(current_state), 32'd0);
    endtask

    initial begin
        int n;
        int ofs;
        int len;
        int ext_visits;
        int ack0;
        bit lng;

        rst       = 1'b1;
        ce_decode = 1'b0;
        fo_full   = 1'b0;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // IDLE holds without decode enable, then moves to TOKEN
        repeat (3) @(negedge clk);
        check("idle_hold", 32'(current_state), 32'd0);
        ce_decode = 1'b1;
        @(negedge clk);
        check("idle_to_token", 32'(current_state), 32'd1);

        // Two literals, one byte per cycle
        clear_seg();
        enc_lit(8'h41);
        enc_lit(8'h42);
        drain("lit", 100, 1'b0);
        compare_seg("lit");
        if (got_t.size() >= 2) check("lit_rate", 32'(got_t[1] - got_t[0]), 32'd1);

        // Short overlapping copy, two cycles per copied byte
        clear_seg();
        enc_lit(8'h41);
        enc_copy(1, 2, 1'b0);
        drain("short", 100, 1'b0);
        compare_seg("short");
        if (got_t.size() >= 3) check("copy_rate", 32'(got_t[2] - got_t[1]), 32'd2);

        // Extended length 26 needs two EXT nibbles
        clear_seg();
        enc_lit(8'h55);
        enc_copy(1, 26, 1'b0);
        drain("ext", 200, 1'b0);
        compare_seg("ext");
        ext_visits = 0;
        foreach (ackst_q[i]) if (ackst_q[i] == 3) ext_visits++;
        check("ext_visits", 32'(ext_visits), 32'd2);

        // Random token mix under random stalls
        clear_seg();
        for (int t = 0; t < 40; t++) begin
            if (hist_m.size() == 0 || $urandom_range(0, 1) == 0) begin
                enc_lit(8'($urandom));
            end else begin
                n   = (hist_m.size() > 2047) ? 2047 : hist_m.size();
                ofs = $urandom_range(1, n);
                len = $urandom_range(2, 40);
                lng = (ofs > 127) ? 1'b1 : 1'($urandom_range(0, 1));
                enc_copy(ofs, len, lng);
            end
        end
        drain("rand", 20000, 1'b1);
        compare_seg("rand");

        // Write-pointer wrap: fresh history, 2100 literals, long-offset copy of 4 back
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hist_m.delete();
        clear_seg();
        for (int i = 0; i < 2100; i++) enc_lit(8'(i & 255));
        enc_copy(4, 3, 1'b1);
        drain("wrap", 10000, 1'b0);
        compare_seg("wrap");
        if (got_q.size() >= 2103) begin
            check("wrap_b0", 32'(got_q[2100]), 32'h30);
            check("wrap_b2", 32'(got_q[2102]), 32'h32);
        end

        // Back-pressure mid-copy freezes the decoder
        clear_seg();
        enc_lit(8'h3C);
        enc_lit(8'hA5);
        enc_copy(2, 10, 1'b0);
        n = 0;
        while (current_state != 3'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_reach_wr", 32'(current_state), 32'd5);
        fo_full = 1'b1;
        ack0    = ack_cnt;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd0);
            check("bp_ack", 32'(stream_ack), 32'd0);
            check("bp_state", 32'(current_state), 32'd5);
        end
        check("bp_no_acks", 32'(ack_cnt), 32'(ack0));
        fo_full = 1'b0;
        drain("bp", 200, 1'b0);
        compare_seg("bp");

        // End marker: sticky flag, no further consumption or output
        clear_seg();
        enc_end();
        push_bits(32'(0), 13);
        n = 0;
        while (current_state != 3'd6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("end_state", 32'(current_state), 32'd6);
        check("end_flag", 32'(all_end), 32'd1);
        ack0 = ack_cnt;
        repeat (10) @(negedge clk);
        check("end_no_acks", 32'(ack_cnt), 32'(ack0));
        check("end_no_out", 32'(got_q.size()), 32'd0);
        check("end_pad_left", 32'(src_q.size()), 32'd13);
        check("end_sticky", 32'(all_end), 32'd1);

        rst = 1'b1;
        #1;
        check_zero_outputs("end_reset");
        src_q.delete();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
